alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, 32-step radix-2 Booth multiply
// and 32-step restoring divide, sequenced by an IDLE/RUN/FIN controller.
module alu_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  localparam logic [3:0] OpAdd = 4'h1;
  localparam logic [3:0] OpSub = 4'h2;
  localparam logic [3:0] OpDiv = 4'h3;
  localparam logic [3:0] OpMul = 4'h4;
  localparam logic [3:0] OpAnd = 4'h5;
  localparam logic [3:0] OpOr  = 4'h6;
  localparam logic [3:0] OpLsr = 4'h7;
  localparam logic [3:0] OpAsr = 4'h8;
  localparam logic [3:0] OpShl = 4'h9;
  localparam logic [3:0] OpRor = 4'hA;
  localparam logic [3:0] OpRol = 4'hB;

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [32:0] acc_hi_q, acc_hi_d;  // Booth partial product (signed) or divide remainder
  logic [31:0] acc_lo_q, acc_lo_d;  // Booth multiplier bits or dividend/quotient shift reg
  logic        booth_q, booth_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] result_lo_q, result_lo_d, result_hi_q, result_hi_d;
  logic        err_q, err_d;

  logic [31:0] a_in_mag, b_mag;
  logic [32:0] m_ext, booth_sum;
  logic [65:0] booth_shr;
  logic [32:0] div_shift, div_trial;
  logic [31:0] rem_next, quo_next, quo_fix, rem_fix;
  logic        multi;

  assign a_in_mag = a[31] ? (~a + 32'd1) : a;
  assign b_mag    = b_q[31] ? (~b_q + 32'd1) : b_q;
  assign multi    = (op_q == OpMul) || ((op_q == OpDiv) && (b_q != 32'd0));

  // Booth step: add/subtract multiplicand per {q0, q-1}, then arithmetic shift right.
  assign m_ext = {a_q[31], a_q};
  always_comb begin
    booth_sum = acc_hi_q;
    unique case ({acc_lo_q[0], booth_q})
      2'b01:   booth_sum = acc_hi_q + m_ext;
      2'b10:   booth_sum = acc_hi_q - m_ext;
      default: booth_sum = acc_hi_q;
    endcase
  end
  assign booth_shr = {booth_sum[32], booth_sum, acc_lo_q};

  // Restoring divide step on magnitudes; quotient bits shift in as dividend bits shift out.
  assign div_shift = {acc_hi_q[31:0], acc_lo_q[31]};
  assign div_trial = div_shift - {1'b0, b_mag};
  assign rem_next  = div_trial[32] ? div_shift[31:0] : div_trial[31:0];
  assign quo_next  = {acc_lo_q[30:0], ~div_trial[32]};
  assign quo_fix   = (a_q[31] ^ b_q[31]) ? (~quo_next + 32'd1) : quo_next;
  assign rem_fix   = a_q[31] ? (~rem_next + 32'd1) : rem_next;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    booth_d     = booth_q;
    count_d     = count_q;
    result_lo_d = result_lo_q;
    result_hi_d = result_hi_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          op_d     = op;
          a_d      = a;
          b_d      = b;
          err_d    = 1'b0;
          count_d  = 5'd0;
          acc_hi_d = 33'd0;
          booth_d  = 1'b0;
          acc_lo_d = (op == OpDiv) ? a_in_mag : b;
        end
      end
      StRun: begin
        if (multi) begin
          count_d = count_q + 5'd1;
          if (op_q == OpMul) begin
            acc_hi_d = booth_shr[65:33];
            acc_lo_d = booth_shr[32:1];
            booth_d  = booth_shr[0];
          end else begin
            acc_hi_d = {1'b0, rem_next};
            acc_lo_d = quo_next;
          end
          if (count_q == 5'd31) begin
            state_d = StFin;
            if (op_q == OpMul) begin
              result_hi_d = booth_shr[64:33];
              result_lo_d = booth_shr[32:1];
            end else begin
              result_hi_d = rem_fix;
              result_lo_d = quo_fix;
            end
          end
        end else begin
          state_d     = StFin;
          result_hi_d = 32'd0;
          case (op_q)
            OpAdd:   result_lo_d = a_q + b_q;
            OpSub:   result_lo_d = a_q - b_q;
            OpAnd:   result_lo_d = a_q & b_q;
            OpOr:    result_lo_d = a_q | b_q;
            OpLsr:   result_lo_d = {1'b0, a_q[31:1]};
            OpAsr:   result_lo_d = {a_q[31], a_q[31:1]};
            OpShl:   result_lo_d = {a_q[30:0], 1'b0};
            OpRor:   result_lo_d = {a_q[0], a_q[31:1]};
            OpRol:   result_lo_d = {a_q[30:0], a_q[31]};
            OpDiv: begin
              result_lo_d = 32'd0;
              err_d       = 1'b1;
            end
            default: begin
              // Illegal op: flag only, previous results stay visible.
              result_lo_d = result_lo_q;
              result_hi_d = result_hi_q;
              err_d       = 1'b1;
            end
          endcase
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q     <= StIdle;
      op_q        <= 4'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      acc_hi_q    <= 33'd0;
      acc_lo_q    <= 32'd0;
      booth_q     <= 1'b0;
      count_q     <= 5'd0;
      result_lo_q <= 32'd0;
      result_hi_q <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      booth_q     <= booth_d;
      count_q     <= count_d;
      result_lo_q <= result_lo_d;
      result_hi_q <= result_hi_d;
      err_q       <= err_d;
    end
  end

  assign busy      = (state_q == StRun) || (state_q == StFin);
  assign done      = (state_q == StFin);
  assign result_lo = result_lo_q;
  assign result_hi = result_hi_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Table-driven bench for alu_sequencer with a result scoreboard, plus hand-written
// sequences for clear-during-run and start held high.
module tb_alu_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done, err;
  logic [31:0] result_lo, result_hi;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        err;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        err;
    int          lat;
  } vec_t;

  localparam int NumVec = 22;
  vec_t vecs [NumVec];
  exp_t sb[$];

  alu_sequencer dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .err       (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the edge leaving FIN.
  task automatic do_op(input string name, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] elo, input logic [31:0] ehi,
                       input logic eerr, input int lat);
    exp_t e;
    int   n;
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    op    = 4'($urandom_range(15));
    a     = $urandom;
    b     = $urandom;
    check({name, " busy_at_accept"}, 32'(busy), 32'd1);
    sb.push_back('{lo: elo, hi: ehi, err: eerr});
    n = 0;
    while (!done && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    check({name, " latency"}, n, lat);
    e = sb.pop_front();
    check({name, " result_lo"}, result_lo, e.lo);
    check({name, " result_hi"}, result_hi, e.hi);
    check({name, " err"}, 32'(err), 32'(e.err));
    @(posedge clock); #1;
    check({name, " done_pulse_end"}, 32'(done), 32'd0);
    check({name, " results_hold"}, result_lo, e.lo);
  endtask

  initial begin
    int   seen;
    exp_t e;

    vecs[0]  = '{4'h1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1};
    vecs[1]  = '{4'h2, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 32'h0, 1'b0, 1};
    vecs[2]  = '{4'h5, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 1'b0, 1};
    vecs[3]  = '{4'h6, 32'h12340000, 32'h00005678, 32'h12345678, 32'h0, 1'b0, 1};
    vecs[4]  = '{4'h7, 32'h80000001, 32'hFFFFFFFF, 32'h40000000, 32'h0, 1'b0, 1};
    vecs[5]  = '{4'h8, 32'h80000001, 32'h00000000, 32'hC0000000, 32'h0, 1'b0, 1};
    vecs[6]  = '{4'h9, 32'h80000001, 32'h12345678, 32'h00000002, 32'h0, 1'b0, 1};
    vecs[7]  = '{4'hA, 32'h00000003, 32'h00000000, 32'h80000001, 32'h0, 1'b0, 1};
    vecs[8]  = '{4'hB, 32'h80000001, 32'h00000000, 32'h00000003, 32'h0, 1'b0, 1};
    vecs[9]  = '{4'h4, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 32};
    vecs[10] = '{4'h4, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0, 32};
    vecs[11] = '{4'h3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 32};
    vecs[12] = '{4'h3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 32};
    vecs[13] = '{4'h3, 32'h00000005, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1};
    vecs[14] = '{4'hF, 32'h00000005, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1};
    vecs[15] = '{4'h1, 32'h00000001, 32'h00000002, 32'h00000003, 32'h00000000, 1'b0, 1};
    vecs[16] = '{4'h0, 32'hDEADBEEF, 32'h00000001, 32'h00000003, 32'h00000000, 1'b1, 1};
    vecs[17] = '{4'h4, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b0, 32};
    vecs[18] = '{4'hC, 32'h00000001, 32'h00000001, 32'h00000000, 32'h00000001, 1'b1, 1};
    vecs[19] = '{4'h3, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 32};
    vecs[20] = '{4'h3, 32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'h00000002, 1'b0, 32};
    vecs[21] = '{4'h4, 32'h12345678, 32'h00000002, 32'h2468ACF0, 32'h00000000, 1'b0, 32};

    clear = 1'b1;
    start = 1'b0;
    op    = 4'h0;
    a     = 32'h0;
    b     = 32'h0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset result_lo", result_lo, 32'd0);
    check("reset result_hi", result_hi, 32'd0);
    #22 clear = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < NumVec; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].lo, vecs[i].hi, vecs[i].err, vecs[i].lat);
    end

    // Clear in the middle of a multiply aborts it without a done pulse.
    op    = 4'h4;
    a     = 32'h00000003;
    b     = 32'h00000005;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #3 clear = 1'b1;
    #1;
    check("clear busy", 32'(busy), 32'd0);
    check("clear done", 32'(done), 32'd0);
    check("clear err", 32'(err), 32'd0);
    check("clear result_lo", result_lo, 32'd0);
    check("clear result_hi", result_hi, 32'd0);
    #3 clear = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (done) seen++;
    end
    check("clear no_done", seen, 0);
    do_op("post_clear sub", 4'h2, 32'd3, 32'd5, 32'hFFFFFFFE, 32'h0, 1'b0, 1);

    // Start held high: re-accepted every third cycle, FIN-cycle start ignored.
    op    = 4'hA;
    a     = 32'h00000001;
    b     = 32'h0;
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (i % 3 == 0) sb.push_back('{lo: 32'h80000000, hi: 32'h0, err: 1'b0});
      check($sformatf("held busy%0d", i), 32'(busy), 32'((i % 3) != 2));
      check($sformatf("held done%0d", i), 32'(done), 32'((i % 3) == 1));
      if (done && sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("held result_lo%0d", i), result_lo, e.lo);
        check($sformatf("held err%0d", i), 32'(err), 32'(e.err));
      end
    end
    start = 1'b0;
    check("scoreboard empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
